// File: rtl/moving_average_filter.sv
// Stereo running-sum moving-average filter with a per-channel circular buffer.
// Supports valid/ready handshakes, bypass, buffer flush and a primed flag.
//  state | meaning
//  FLUSH | zero one buffer entry per cycle; sums/ptr/fill held at zero
//  IDLE  | in_ready=1, accept a pair or start a flush on clear
//  ACC   | update running sums and buffer, load outputs
//  OUT   | out_valid=1, hold outputs until out_ready
module moving_average_filter #(
   parameter int DATA_W    = 24,
   parameter int LOG2_TAPS = 3
) (
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   input  logic                     bypass,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_left,
   input  logic signed [DATA_W-1:0] in_right,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_left,
   output logic signed [DATA_W-1:0] out_right,
   output logic                     primed
);

   localparam int TAPS  = 1 << LOG2_TAPS;
   localparam int SUM_W = DATA_W + LOG2_TAPS;
   localparam logic [LOG2_TAPS:0]   FILL_MAX = (LOG2_TAPS + 1)'(TAPS);
   localparam logic [LOG2_TAPS-1:0] LAST_IDX = LOG2_TAPS'(TAPS - 1);

   localparam logic [1:0] FLUSH = 2'd0;
   localparam logic [1:0] IDLE  = 2'd1;
   localparam logic [1:0] ACC   = 2'd2;
   localparam logic [1:0] OUT   = 2'd3;

   logic [1:0]                state;
   logic [LOG2_TAPS-1:0]      flush_idx;
   logic [LOG2_TAPS-1:0]      ptr;
   logic [LOG2_TAPS:0]        fill;
   logic                      byp_q;
   logic                      pend_clear;
   logic signed [DATA_W-1:0]  new_l, new_r, old_l, old_r;
   logic signed [SUM_W-1:0]   sum_l, sum_r;
   logic signed [SUM_W-1:0]   ext_new_l, ext_new_r, ext_old_l, ext_old_r;
   logic signed [SUM_W-1:0]   next_sum_l, next_sum_r, avg_l, avg_r;
   logic signed [DATA_W-1:0]  buf_l [TAPS];
   logic signed [DATA_W-1:0]  buf_r [TAPS];

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign primed    = (fill == FILL_MAX);

   // Sum is LOG2_TAPS bits wider than a sample, so it cannot overflow.
   always_comb begin
      ext_new_l  = {{LOG2_TAPS{new_l[DATA_W-1]}}, new_l};
      ext_new_r  = {{LOG2_TAPS{new_r[DATA_W-1]}}, new_r};
      ext_old_l  = {{LOG2_TAPS{old_l[DATA_W-1]}}, old_l};
      ext_old_r  = {{LOG2_TAPS{old_r[DATA_W-1]}}, old_r};
      next_sum_l = sum_l + ext_new_l - ext_old_l;
      next_sum_r = sum_r + ext_new_r - ext_old_r;
      avg_l      = next_sum_l >>> LOG2_TAPS;
      avg_r      = next_sum_r >>> LOG2_TAPS;
   end

   always_ff @(posedge CLOCK_50) begin
      if (state == FLUSH) begin
         buf_l[flush_idx] <= '0;
         buf_r[flush_idx] <= '0;
      end else if (state == ACC) begin
         buf_l[ptr] <= new_l;
         buf_r[ptr] <= new_r;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state      <= FLUSH;
         flush_idx  <= '0;
         ptr        <= '0;
         sum_l      <= '0;
         sum_r      <= '0;
         fill       <= '0;
         out_left   <= '0;
         out_right  <= '0;
         pend_clear <= 1'b0;
         byp_q      <= 1'b0;
         new_l      <= '0;
         new_r      <= '0;
         old_l      <= '0;
         old_r      <= '0;
      end else begin
         case (state)
            FLUSH: begin
               sum_l      <= '0;
               sum_r      <= '0;
               ptr        <= '0;
               fill       <= '0;
               pend_clear <= 1'b0;
               if (flush_idx == LAST_IDX) begin
                  flush_idx <= '0;
                  state     <= IDLE;
               end else begin
                  flush_idx <= flush_idx + LOG2_TAPS'(1);
               end
            end
            IDLE: begin
               // Zero fill on entry so primed drops in the first flush cycle.
               if (clear) begin
                  state     <= FLUSH;
                  flush_idx <= '0;
                  sum_l     <= '0;
                  sum_r     <= '0;
                  ptr       <= '0;
                  fill      <= '0;
               end else if (in_valid) begin
                  new_l <= in_left;
                  new_r <= in_right;
                  old_l <= buf_l[ptr];
                  old_r <= buf_r[ptr];
                  byp_q <= bypass;
                  state <= ACC;
               end
            end
            ACC: begin
               sum_l <= next_sum_l;
               sum_r <= next_sum_r;
               ptr   <= ptr + LOG2_TAPS'(1);
               if (fill != FILL_MAX) fill <= fill + (LOG2_TAPS + 1)'(1);
               if (byp_q) begin
                  out_left  <= new_l;
                  out_right <= new_r;
               end else begin
                  out_left  <= avg_l[DATA_W-1:0];
                  out_right <= avg_r[DATA_W-1:0];
               end
               if (clear) pend_clear <= 1'b1;
               state <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  pend_clear <= 1'b0;
                  if (pend_clear || clear) begin
                     state     <= FLUSH;
                     flush_idx <= '0;
                     sum_l     <= '0;
                     sum_r     <= '0;
                     ptr       <= '0;
                     fill      <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (clear) begin
                  pend_clear <= 1'b1;
               end
            end
            default: state <= FLUSH;
         endcase
      end
   end

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: 8 taps, 24-bit samples.
module tb_moving_average_filter;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        bypass = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_left = '0;
   logic [23:0] in_right = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [23:0] out_left;
   logic [23:0] out_right;
   logic        primed;

   int errors = 0;
   int checks = 0;

   moving_average_filter #(.DATA_W(24), .LOG2_TAPS(3)) dut (
      .CLOCK_50  (CLOCK_50),
      .reset_n   (reset_n),
      .bypass    (bypass),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_left   (in_left),
      .in_right  (in_right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_left  (out_left),
      .out_right (out_right),
      .primed    (primed)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      ok = in_ready;
   endtask

   // Drives one pair through with out_ready=1; lat counts edges from presentation to out_valid.
   task automatic xfer(input logic [23:0] l, input logic [23:0] r, input logic byp,
                       output logic [23:0] ol, output logic [23:0] orr,
                       output logic pr, output int lat);
      bit ok;
      wait_ready(ok);
      ol = '0;
      orr = '0;
      pr = 1'b0;
      lat = 99;
      if (!ok) return;
      in_left  = l;
      in_right = r;
      bypass   = byp;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      if (!out_valid) begin
         lat = 99;
         return;
      end
      ol  = out_left;
      orr = out_right;
      pr  = primed;
      step();
   endtask

   task automatic do_clear();
      bit ok;
      wait_ready(ok);
      clear = 1'b1;
      step();
      clear = 1'b0;
      wait_ready(ok);
   endtask

   task automatic test_reset();
      int n;
      int bad;
      reset_n = 1'b0;
      repeat (3) step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed: got %b expected 0", primed); end
      checks++; if (out_left !== 24'h0) begin errors++; $display("FAIL reset_out_left: got %h expected 000000", out_left); end
      reset_n = 1'b1;
      n = 0;
      bad = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
         if (out_valid !== 1'b0 || primed !== 1'b0) bad++;
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL reset_flush_len: got %0d cycles expected 8", n); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL reset_flush_outputs: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_impulse();
      logic [23:0] ol, orr, exp_l;
      logic pr;
      int lat;
      for (int i = 0; i < 10; i++) begin
         xfer((i == 0) ? 24'd800 : 24'd0, 24'd0, 1'b0, ol, orr, pr, lat);
         exp_l = (i < 8) ? 24'd100 : 24'd0;
         checks++; if (ol !== exp_l) begin errors++; $display("FAIL impulse_left[%0d]: got %0d expected %0d", i, ol, exp_l); end
         checks++; if (lat !== 2) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d expected 2", i, lat); end
         checks++; if (pr !== (i >= 7)) begin errors++; $display("FAIL impulse_primed[%0d]: got %b expected %b", i, pr, (i >= 7)); end
      end
   endtask

   task automatic test_signed();
      logic [23:0] ol, orr, exp_r;
      logic pr;
      int lat;
      do_clear();
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL signed_primed_after_clear: got %b expected 0", primed); end
      for (int i = 0; i < 10; i++) begin
         xfer(24'd0, (i == 0) ? 24'hFFFFFF : 24'd0, 1'b0, ol, orr, pr, lat);
         exp_r = (i < 8) ? 24'hFFFFFF : 24'h000000;
         checks++; if (orr !== exp_r) begin errors++; $display("FAIL floor_right[%0d]: got %h expected %h", i, orr, exp_r); end
         checks++; if (ol !== 24'h0) begin errors++; $display("FAIL floor_left[%0d]: got %h expected 000000", i, ol); end
      end
      do_clear();
      for (int i = 0; i < 8; i++) begin
         xfer(24'h7FFFFF, 24'h800000, 1'b0, ol, orr, pr, lat);
         if (i == 0) begin
            checks++; if (ol !== 24'h0FFFFF) begin errors++; $display("FAIL range_first_left: got %h expected 0fffff", ol); end
            checks++; if (orr !== 24'hF00000) begin errors++; $display("FAIL range_first_right: got %h expected f00000", orr); end
         end
      end
      checks++; if (ol !== 24'h7FFFFF) begin errors++; $display("FAIL range_max_left: got %h expected 7fffff", ol); end
      checks++; if (orr !== 24'h800000) begin errors++; $display("FAIL range_min_right: got %h expected 800000", orr); end
      checks++; if (pr !== 1'b1) begin errors++; $display("FAIL range_primed: got %b expected 1", pr); end
   endtask

   task automatic test_clear_during_out();
      logic [23:0] ol, orr;
      logic pr;
      int lat;
      int n;
      bit ok;
      wait_ready(ok);
      out_ready = 1'b0;
      in_left = 24'd800;
      in_right = 24'd0;
      bypass = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_out_valid: got %b expected 1", out_valid); end
      checks++; if (primed !== 1'b1) begin errors++; $display("FAIL clr_primed_before: got %b expected 1", primed); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_still_valid: got %b expected 1", out_valid); end
      checks++; if (out_left !== 24'h700063) begin errors++; $display("FAIL clr_pending_left: got %h expected 700063", out_left); end
      checks++; if (out_right !== 24'h900000) begin errors++; $display("FAIL clr_pending_right: got %h expected 900000", out_right); end
      out_ready = 1'b1;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_flush_in_ready: got %b expected 0", in_ready); end
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL clr_primed_after: got %b expected 0", primed); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid_after: got %b expected 0", out_valid); end
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL clr_flush_len: got %0d cycles expected 8", n); end
      xfer(24'd800, 24'd0, 1'b0, ol, orr, pr, lat);
      checks++; if (ol !== 24'd100) begin errors++; $display("FAIL clr_next_left: got %0d expected 100", ol); end
   endtask

   task automatic test_backpressure();
      logic [23:0] ol, orr;
      logic pr;
      int lat;
      int bad;
      bit ok;
      do_clear();
      out_ready = 1'b0;
      wait_ready(ok);
      in_left = 24'd16;
      in_right = 24'hFFFFF0;
      in_valid = 1'b1;
      step();
      in_left = 24'd24;
      in_right = 24'hFFFFE8;
      step();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_left !== 24'd2 || out_right !== 24'hFFFFFE) bad++;
         step();
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", bad); end
      out_ready = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got %b expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_acc_no_valid: got %b expected 0", out_valid); end
      step();
      checks++; if (out_left !== 24'd5) begin errors++; $display("FAIL bp_second_left: got %0d expected 5", out_left); end
      checks++; if (out_right !== 24'hFFFFFB) begin errors++; $display("FAIL bp_second_right: got %h expected fffffb", out_right); end
      step();
      xfer(24'd0, 24'd0, 1'b0, ol, orr, pr, lat);
      checks++; if (ol !== 24'd5) begin errors++; $display("FAIL bp_no_dup_left: got %0d expected 5", ol); end
      checks++; if (orr !== 24'hFFFFFB) begin errors++; $display("FAIL bp_no_dup_right: got %h expected fffffb", orr); end
   endtask

   task automatic test_bypass();
      logic [23:0] ol, orr;
      logic pr;
      int lat;
      do_clear();
      for (int i = 0; i < 8; i++) xfer(24'd80, 24'hFFFFB0, 1'b0, ol, orr, pr, lat);
      checks++; if (ol !== 24'd80) begin errors++; $display("FAIL byp_full_avg: got %0d expected 80", ol); end
      xfer(24'd8, 24'hFFFFF8, 1'b1, ol, orr, pr, lat);
      checks++; if (ol !== 24'd8) begin errors++; $display("FAIL byp_raw_left: got %0d expected 8", ol); end
      checks++; if (orr !== 24'hFFFFF8) begin errors++; $display("FAIL byp_raw_right: got %h expected fffff8", orr); end
      xfer(24'd8, 24'hFFFFF8, 1'b0, ol, orr, pr, lat);
      checks++; if (ol !== 24'd62) begin errors++; $display("FAIL byp_off_left: got %0d expected 62", ol); end
      checks++; if (orr !== 24'hFFFFC2) begin errors++; $display("FAIL byp_off_right: got %h expected ffffc2", orr); end
   endtask

   task automatic test_mid_reset();
      logic [23:0] ol, orr;
      logic pr;
      int lat;
      int n;
      bit ok;
      wait_ready(ok);
      out_ready = 1'b0;
      in_left = 24'd800;
      in_right = 24'd0;
      bypass = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_pre_valid: got %b expected 1", out_valid); end
      reset_n = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL mid_rst_primed: got %b expected 0", primed); end
      checks++; if (out_left !== 24'd0) begin errors++; $display("FAIL mid_rst_out_left: got %0d expected 0", out_left); end
      reset_n = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL mid_rst_flush_len: got %0d cycles expected 8", n); end
      xfer(24'd800, 24'd0, 1'b0, ol, orr, pr, lat);
      checks++; if (ol !== 24'd100) begin errors++; $display("FAIL mid_rst_next_left: got %0d expected 100", ol); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_signed();
      test_clear_during_out();
      test_backpressure();
      test_bypass();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
